iq_discriminator: RTL and testbench
===================================

// Module: iq_discriminator
// PURPOSE
//  Downstream neighbour of the I/Q channel FIR filters in the iq_demod chain.
//  Consumes filtered I and Q samples over a valid/ready handshake and decimates them by DECIM.
//  Computes the cross-product frequency discriminator d[n] = I[n]*Q[n-1] - Q[n]*I[n-1]
//  and presents d plus a hard chip decision (1 when d>0) to the chip despreader.
// PARAMETERS
//  DATA_W  5   width of signed I/Q input samples (two's complement)
//  DECIM   4   decimation factor; keep 1 of every DECIM accepted samples (DECIM>=1)
//  OUT_W   2*DATA_W+1  width of signed discriminator output (derived, localparam)
// PORTS
//  clk        in   1        clock
//  resetn     in   1        asynchronous active-low reset
//  sync_clr   in   1        synchronous clear of history, decimation counter and pipeline
//  in_valid   in   1        I/Q sample pair valid
//  in_ready   out  1        block accepts sample this cycle
//  i_in       in   DATA_W   filtered I sample, signed
//  q_in       in   DATA_W   filtered Q sample, signed
//  out_valid  out  1        disc_out/chip_out valid
//  out_ready  in   1        downstream accepts output
//  disc_out   out  OUT_W    signed discriminator value
//  chip_out   out  1        hard decision: 1 iff disc_out > 0
// BEHAVIOUR
//  Reset (resetn=0, async): out_valid=0, disc_out=0, chip_out=0, in_ready=1; counter, history,
//   primed flag and all stage valids cleared.
//  Handshake: a transfer occurs on a clk edge with valid&ready high. out_valid/disc_out/chip_out
//   stay stable while out_valid=1 and out_ready=0.
//  Pipeline enable: en = ~out_valid | out_ready; in_ready = en. en=0 freezes every stage. No bubble
//   collapse is required.
//  Decimation: dcnt counts 0..DECIM-1 on each accepted input and wraps to 0. The sample is kept
//   when dcnt==DECIM-1. Non-kept samples are accepted and discarded.
//  Stage A (on kept accept): cur<=(i_in,q_in); prev<=old cur. When primed=0, set primed=1 and do
//   not mark stage A valid. The first kept sample only primes history.
//  Stage B: p1 = i_cur*q_prev, p2 = q_cur*i_prev, each 2*DATA_W signed, registered.
//  Stage C: disc = sext(p1) - sext(p2), registered to disc_out. chip_out = (disc>0).
//   Full precision is kept with no saturation or rounding (|d| <= 2^(2*DATA_W-1) - 2^(DATA_W-1)).
//  Latency: a kept, primed sample accepted at edge k gives out_valid=1 after edge k+2
//   when out_ready stays high. Throughput is 1 output per kept sample.
//  sync_clr=1: on the next edge clear dcnt, primed, cur/prev and all stage valids.
//   out_valid goes to 0 even if out_ready=0, so in-flight results are dropped.
//   sync_clr takes priority over a simultaneous input transfer; in_ready still reads en,
//   but the sample is discarded.
//  DECIM=1: every sample is kept. The counter logic must synthesize away cleanly.
//  Reset mid-operation: async clear as above. There is no partial output after release.
// STRUCTURE
//  iq_demod_pkg holds DATA_W and the iq_sample_t typedef (struct packed {logic signed
//   [DATA_W-1:0] i, q;}), shared with the filters.
//  Sub-module iq_cross_mult handles stage B: a registered pair of signed multiplies with enable.
//  The top level holds the decimation counter, history registers, valid pipeline and stage C.
// TESTING
//  Reset: hold resetn=0 and toggle clk -> out_valid=0, disc_out=0, chip_out=0, in_ready=1.
//  DECIM=1, out_ready=1: (0,4) then (4,0) -> one output 2 cycles after 2nd accept, disc=16, chip=1.
//  Extremes DECIM=1: (-16,-16) then (-16,15) -> disc=496, chip=1. (-16,15) then (-16,-16) -> -496, chip 0.
//  DECIM=4: 8 back-to-back samples, only #3 (0,4) and #7 (4,0) nonzero -> exactly one output, disc=16.
//  Backpressure: stream 10 samples DECIM=1 with out_ready=0 for 5 cycles -> in_ready falls,
//   outputs stay stable, and all 9 expected results arrive in order with none lost.
//  sync_clr mid-stream: pulse while 2 results are in flight -> out_valid=0 next cycle,
//   and the next kept sample primes with no output.

Source files
------------

// File: rtl/iq_demod_pkg.sv
// Shared types and sizing helpers for the iq_demod chain (filters, discriminator, despreader).
package iq_demod_pkg;

   localparam int DATA_W = 5;

   typedef struct packed {
      logic signed [DATA_W-1:0] i;
      logic signed [DATA_W-1:0] q;
   } iq_sample_t;

   // Full-precision width of I[n]*Q[n-1] - Q[n]*I[n-1] for w-bit signed inputs.
   function automatic int disc_width(input int w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/iq_discriminator_if.sv
// Stream interface for the discriminator: I/Q samples in, discriminator value and chip out.
interface iq_discriminator_if
   import iq_demod_pkg::*;
#(
   parameter int DATA_W = iq_demod_pkg::DATA_W
) ();

   localparam int OUT_W = disc_width(DATA_W);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] i_in;
   logic signed [DATA_W-1:0] q_in;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  disc_out;
   logic                     chip_out;

   modport master (
      output in_valid, i_in, q_in, out_ready,
      input  in_ready, out_valid, disc_out, chip_out
   );

   modport slave (
      input  in_valid, i_in, q_in, out_ready,
      output in_ready, out_valid, disc_out, chip_out
   );

endinterface

// File: rtl/iq_cross_mult.sv
// Registered pair of signed cross products I[n]*Q[n-1] and Q[n]*I[n-1], with stage enable.
module iq_cross_mult #(
   parameter int DATA_W = 5
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       clr,
   input  logic                       en,
   input  logic                       valid_in,
   input  logic signed [DATA_W-1:0]   i_cur,
   input  logic signed [DATA_W-1:0]   q_cur,
   input  logic signed [DATA_W-1:0]   i_prev,
   input  logic signed [DATA_W-1:0]   q_prev,
   output logic signed [2*DATA_W-1:0] p1,
   output logic signed [2*DATA_W-1:0] p2,
   output logic                       valid_out
);

   localparam int PROD_W = 2 * DATA_W;

   logic signed [DATA_W-1:0] mul_a [2];
   logic signed [DATA_W-1:0] mul_b [2];
   logic signed [PROD_W-1:0] prod [2];
   logic                     valid_reg;

   assign mul_a[0] = i_cur;
   assign mul_b[0] = q_prev;
   assign mul_a[1] = q_cur;
   assign mul_b[1] = i_prev;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mul
         logic signed [PROD_W-1:0] prod_reg;
         // Operands are widened first so the product is exact at 2*DATA_W bits.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               prod_reg <= '0;
            end else if (en) begin
               prod_reg <= PROD_W'(mul_a[gi]) * PROD_W'(mul_b[gi]);
            end
         end
         assign prod[gi] = prod_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_reg <= 1'b0;
      end else if (clr) begin
         valid_reg <= 1'b0;
      end else if (en) begin
         valid_reg <= valid_in;
      end
   end

   assign p1        = prod[0];
   assign p2        = prod[1];
   assign valid_out = valid_reg;

endmodule

// File: rtl/iq_discriminator.sv
// Decimating cross-product FM discriminator: d[n] = I[n]*Q[n-1] - Q[n]*I[n-1], chip = (d > 0).
module iq_discriminator
   import iq_demod_pkg::*;
#(
   parameter int DATA_W = iq_demod_pkg::DATA_W,
   parameter int DECIM  = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               sync_clr,
   iq_discriminator_if.slave  bus
);

   localparam int OUT_W  = disc_width(DATA_W);
   localparam int PROD_W = 2 * DATA_W;

   logic                     en;
   logic                     accept;
   logic                     keep;
   logic signed [DATA_W-1:0] i_cur_reg, q_cur_reg, i_prev_reg, q_prev_reg;
   logic                     primed_reg;
   logic                     va_reg;
   logic                     vb;
   logic signed [PROD_W-1:0] p1, p2;
   logic signed [OUT_W-1:0]  disc_next;
   logic signed [OUT_W-1:0]  disc_reg;
   logic                     out_valid_reg;

   // A single global enable: any stall at the output freezes the whole pipe.
   assign en     = ~out_valid_reg | bus.out_ready;
   assign accept = bus.in_valid & en & ~sync_clr;

   generate
      if (DECIM > 1) begin : g_decim
         localparam int               CNT_W = $clog2(DECIM);
         localparam logic [CNT_W-1:0] LAST  = CNT_W'(DECIM - 1);
         logic [CNT_W-1:0] dcnt_reg;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               dcnt_reg <= '0;
            end else if (sync_clr) begin
               dcnt_reg <= '0;
            end else if (accept) begin
               dcnt_reg <= (dcnt_reg == LAST) ? '0 : dcnt_reg + 1'b1;
            end
         end

         assign keep = accept & (dcnt_reg == LAST);
      end else begin : g_no_decim
         assign keep = accept;
      end
   endgenerate

   // Stage A: sample history. The first kept sample after clear only primes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_cur_reg  <= '0;
         q_cur_reg  <= '0;
         i_prev_reg <= '0;
         q_prev_reg <= '0;
         primed_reg <= 1'b0;
         va_reg     <= 1'b0;
      end else if (sync_clr) begin
         i_cur_reg  <= '0;
         q_cur_reg  <= '0;
         i_prev_reg <= '0;
         q_prev_reg <= '0;
         primed_reg <= 1'b0;
         va_reg     <= 1'b0;
      end else if (en) begin
         va_reg <= keep & primed_reg;
         if (keep) begin
            i_cur_reg  <= bus.i_in;
            q_cur_reg  <= bus.q_in;
            i_prev_reg <= i_cur_reg;
            q_prev_reg <= q_cur_reg;
            primed_reg <= 1'b1;
         end
      end
   end

   iq_cross_mult #(
      .DATA_W (DATA_W)
   ) u_cross_mult (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (sync_clr),
      .en        (en),
      .valid_in  (va_reg),
      .i_cur     (i_cur_reg),
      .q_cur     (q_cur_reg),
      .i_prev    (i_prev_reg),
      .q_prev    (q_prev_reg),
      .p1        (p1),
      .p2        (p2),
      .valid_out (vb)
   );

   assign disc_next = OUT_W'(p1) - OUT_W'(p2);

   // Stage C: output register; data only moves when a valid result arrives.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disc_reg      <= '0;
         out_valid_reg <= 1'b0;
      end else if (sync_clr) begin
         out_valid_reg <= 1'b0;
      end else if (en) begin
         out_valid_reg <= vb;
         if (vb) begin
            disc_reg <= disc_next;
         end
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_reg;
   assign bus.disc_out  = disc_reg;
   assign bus.chip_out  = ~disc_reg[OUT_W-1] & (|disc_reg);

endmodule

// File: tb/tb_iq_discriminator.sv
// Self-checking bench for iq_discriminator: DECIM=1 and DECIM=4 instances against a sample-level model.
module tb_iq_discriminator;
   import iq_demod_pkg::*;

   localparam int DW = DATA_W;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic clr1   = 1'b0;
   logic clr4   = 1'b0;

   always #5 clk = ~clk;

   iq_discriminator_if #(.DATA_W(DW)) b1 ();
   iq_discriminator_if #(.DATA_W(DW)) b4 ();

   iq_discriminator #(.DATA_W(DW), .DECIM(1)) dut1 (
      .clk(clk), .resetn(resetn), .sync_clr(clr1), .bus(b1)
   );
   iq_discriminator #(.DATA_W(DW), .DECIM(4)) dut4 (
      .clk(clk), .resetn(resetn), .sync_clr(clr4), .bus(b4)
   );

   int errors = 0;
   int checks = 0;

   int exp1[$], obs1[$], exp4[$], obs4[$];
   bit oc1[$], oc4[$];

   // Reference model: per kept sample, d = I*Qlast - Q*Ilast once history is primed.
   int m_cnt1, m_li1, m_lq1, t_i1, t_q1;
   bit m_pr1;
   int m_cnt4, m_li4, m_lq4, t_i4, t_q4;
   bit m_pr4;

   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            m_cnt1 = 0; m_pr1 = 0;
            while (exp1.size() > obs1.size()) void'(exp1.pop_back());
         end else begin
            if (b1.out_valid && b1.out_ready) begin
               obs1.push_back(int'(b1.disc_out));
               oc1.push_back(b1.chip_out);
            end
            if (clr1) begin
               m_cnt1 = 0; m_pr1 = 0;
               while (exp1.size() > obs1.size()) void'(exp1.pop_back());
            end else if (b1.in_valid && b1.in_ready) begin
               t_i1 = int'(b1.i_in); t_q1 = int'(b1.q_in);
               m_cnt1 = m_cnt1 + 1;
               if (m_cnt1 == 1) begin
                  m_cnt1 = 0;
                  if (m_pr1) exp1.push_back(t_i1 * m_lq1 - t_q1 * m_li1);
                  m_pr1 = 1; m_li1 = t_i1; m_lq1 = t_q1;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            m_cnt4 = 0; m_pr4 = 0;
            while (exp4.size() > obs4.size()) void'(exp4.pop_back());
         end else begin
            if (b4.out_valid && b4.out_ready) begin
               obs4.push_back(int'(b4.disc_out));
               oc4.push_back(b4.chip_out);
            end
            if (clr4) begin
               m_cnt4 = 0; m_pr4 = 0;
               while (exp4.size() > obs4.size()) void'(exp4.pop_back());
            end else if (b4.in_valid && b4.in_ready) begin
               t_i4 = int'(b4.i_in); t_q4 = int'(b4.q_in);
               m_cnt4 = m_cnt4 + 1;
               if (m_cnt4 == 4) begin
                  m_cnt4 = 0;
                  if (m_pr4) exp4.push_back(t_i4 * m_lq4 - t_q4 * m_li4);
                  m_pr4 = 1; m_li4 = t_i4; m_lq4 = t_q4;
               end
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit sel);
      if (sel) b4.in_valid = 1'b0;
      else     b1.in_valid = 1'b0;
   endtask

   task automatic pulse_clr(input bit sel);
      if (sel) clr4 = 1'b1;
      else     clr1 = 1'b1;
      wait_cycles(1);
      clr1 = 1'b0;
      clr4 = 1'b0;
   endtask

   // Present one sample and return just after the edge that accepts it.
   task automatic drive(input bit sel, input int i, input int q);
      int n;
      bit rdy;
      n = 0;
      if (sel) begin
         b4.in_valid = 1'b1; b4.i_in = i[DW-1:0]; b4.q_in = q[DW-1:0];
      end else begin
         b1.in_valid = 1'b1; b1.i_in = i[DW-1:0]; b1.q_in = q[DW-1:0];
      end
      forever begin
         @(negedge clk);
         rdy = sel ? (b4.in_ready && !clr4) : (b1.in_ready && !clr1);
         if (rdy) break;
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL drive_timeout: sel=%0d in_ready stayed low, required accept within 200 cycles", sel);
            break;
         end
      end
      wait_cycles(1);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov1: got %b want 0", b1.out_valid); end
      checks++; if (b1.disc_out !== '0) begin errors++; $display("FAIL reset_disc1: got %0d want 0", b1.disc_out); end
      checks++; if (b1.chip_out !== 1'b0) begin errors++; $display("FAIL reset_chip1: got %b want 0", b1.chip_out); end
      checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy1: got %b want 1", b1.in_ready); end
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov4: got %b want 0", b4.out_valid); end
      checks++; if (b4.disc_out !== '0) begin errors++; $display("FAIL reset_disc4: got %0d want 0", b4.disc_out); end
      checks++; if (b4.chip_out !== 1'b0) begin errors++; $display("FAIL reset_chip4: got %b want 0", b4.chip_out); end
      checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy4: got %b want 1", b4.in_ready); end
      @(posedge clk); #1;
      resetn = 1'b1;
      wait_cycles(1);
   endtask

   task automatic test_basic;
      int base;
      pulse_clr(0);
      base = obs1.size();
      drive(0, 0, 4);
      drive(0, 4, 0);
      idle(0);
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_k0: out_valid %b want 0", b1.out_valid); end
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_k1: out_valid %b want 0", b1.out_valid); end
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_k2: out_valid %b want 1", b1.out_valid); end
      checks++; if (int'(b1.disc_out) !== 16) begin errors++; $display("FAIL basic_disc: got %0d want 16", b1.disc_out); end
      checks++; if (b1.chip_out !== 1'b1) begin errors++; $display("FAIL basic_chip: got %b want 1", b1.chip_out); end
      wait_cycles(3);
      checks++; if (obs1.size() !== base + 1) begin errors++; $display("FAIL basic_count: got %0d outputs want 1", obs1.size() - base); end
      $display("basic: (0,4),(4,0) -> disc=%0d chip=%b", b1.disc_out, b1.chip_out);
   endtask

   task automatic test_extremes;
      int ai[2] = '{-16, -16};
      int aq[2] = '{-16, 15};
      int bi[2] = '{-16, -16};
      int bq[2] = '{15, -16};
      int want[2] = '{496, -496};
      int base;
      for (int k = 0; k < 2; k++) begin
         pulse_clr(0);
         base = obs1.size();
         drive(0, ai[k], aq[k]);
         drive(0, bi[k], bq[k]);
         idle(0);
         wait_cycles(4);
         checks++;
         if (obs1.size() !== base + 1) begin
            errors++; $display("FAIL extreme%0d_count: got %0d outputs want 1", k, obs1.size() - base);
         end else begin
            checks++; if (obs1[base] !== want[k]) begin errors++; $display("FAIL extreme%0d_disc: got %0d want %0d", k, obs1[base], want[k]); end
            checks++; if (oc1[base] !== (want[k] > 0)) begin errors++; $display("FAIL extreme%0d_chip: got %b want %b", k, oc1[base], want[k] > 0); end
            $display("extreme%0d: disc=%0d chip=%b", k, obs1[base], oc1[base]);
         end
      end
   endtask

   task automatic test_decim4;
      int base;
      pulse_clr(1);
      base = obs4.size();
      for (int k = 0; k < 8; k++) drive(1, (k == 7) ? 4 : 0, (k == 3) ? 4 : 0);
      idle(1);
      wait_cycles(5);
      checks++;
      if (obs4.size() !== base + 1) begin
         errors++; $display("FAIL decim4_count: got %0d outputs want 1", obs4.size() - base);
      end else begin
         checks++; if (obs4[base] !== 16) begin errors++; $display("FAIL decim4_disc: got %0d want 16", obs4[base]); end
         checks++; if (oc4[base] !== 1'b1) begin errors++; $display("FAIL decim4_chip: got %b want 1", oc4[base]); end
         $display("decim4: 8 samples -> disc=%0d chip=%b", obs4[base], oc4[base]);
      end
      checks++; if (exp4.size() !== obs4.size()) begin errors++; $display("FAIL decim4_model: outputs %0d model expects %0d", obs4.size(), exp4.size()); end
   endtask

   task automatic test_backpressure;
      int si[10], sq[10];
      int base, want, n;
      logic signed [DW*2:0] held;
      pulse_clr(0);
      base = obs1.size();
      for (int k = 0; k < 10; k++) begin
         si[k] = int'($urandom_range(0, 31)) - 16;
         sq[k] = int'($urandom_range(0, 31)) - 16;
      end
      fork
         begin
            for (int k = 0; k < 10; k++) drive(0, si[k], sq[k]);
            idle(0);
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!b1.out_valid && n < 100);
            @(posedge clk); #1;
            b1.out_ready = 1'b0;
            @(negedge clk);
            held = b1.disc_out;
            checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_start: out_valid %b want 1", b1.out_valid); end
            for (int c = 0; c < 5; c++) begin
               if (c > 0) @(negedge clk);
               checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, b1.in_ready); end
               checks++; if (b1.out_valid !== 1'b1 || b1.disc_out !== held) begin
                  errors++; $display("FAIL bp_stable c%0d: valid=%b disc=%0d want valid=1 disc=%0d", c, b1.out_valid, b1.disc_out, held);
               end
            end
            @(posedge clk); #1;
            b1.out_ready = 1'b1;
         end
      join
      wait_cycles(8);
      checks++;
      if (obs1.size() !== base + 9) begin
         errors++; $display("FAIL bp_count: got %0d outputs want 9", obs1.size() - base);
      end else begin
         for (int k = 0; k < 9; k++) begin
            want = si[k+1] * sq[k] - sq[k+1] * si[k];
            checks++;
            if (obs1[base+k] !== want || oc1[base+k] !== (want > 0)) begin
               errors++; $display("FAIL bp_result%0d: got disc=%0d chip=%b want disc=%0d chip=%b", k, obs1[base+k], oc1[base+k], want, want > 0);
            end else begin
               $display("bp out%0d: disc=%0d chip=%b", k, obs1[base+k], oc1[base+k]);
            end
         end
      end
   endtask

   task automatic test_sync_clr;
      int si[5], sq[5];
      int base, want;
      bit stray;
      pulse_clr(0);
      base = obs1.size();
      for (int k = 0; k < 5; k++) begin
         si[k] = int'($urandom_range(0, 31)) - 16;
         sq[k] = int'($urandom_range(0, 31)) - 16;
      end
      for (int k = 0; k < 3; k++) drive(0, si[k], sq[k]);
      idle(0);
      clr1 = 1'b1;
      wait_cycles(1);
      clr1 = 1'b0;
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL clr_drop: out_valid %b want 0", b1.out_valid); end
      stray = 1'b0;
      repeat (4) begin @(negedge clk); if (b1.out_valid !== 1'b0) stray = 1'b1; end
      checks++; if (stray) begin errors++; $display("FAIL clr_quiet: out_valid rose after clear, want 0"); end
      @(posedge clk); #1;
      drive(0, si[3], sq[3]);
      idle(0);
      stray = 1'b0;
      repeat (5) begin @(negedge clk); if (b1.out_valid !== 1'b0) stray = 1'b1; end
      checks++; if (stray) begin errors++; $display("FAIL clr_prime: output after priming sample, want none"); end
      @(posedge clk); #1;
      drive(0, si[4], sq[4]);
      idle(0);
      wait_cycles(4);
      want = si[4] * sq[3] - sq[4] * si[3];
      checks++;
      if (obs1.size() !== base + 1) begin
         errors++; $display("FAIL clr_count: got %0d outputs want 1", obs1.size() - base);
      end else begin
         checks++; if (obs1[base] !== want) begin errors++; $display("FAIL clr_disc: got %0d want %0d", obs1[base], want); end
         $display("sync_clr: post-clear disc=%0d", obs1[base]);
      end
   endtask

   task automatic test_reset_mid;
      int base;
      pulse_clr(0);
      for (int k = 0; k < 4; k++) drive(0, int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16);
      idle(0);
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (b1.out_valid !== 1'b0 || b1.disc_out !== '0 || b1.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid: valid=%b disc=%0d rdy=%b want 0 0 1", b1.out_valid, b1.disc_out, b1.in_ready);
      end
      @(negedge clk);
      @(posedge clk); #1;
      resetn = 1'b1;
      base = obs1.size();
      wait_cycles(6);
      checks++; if (obs1.size() !== base) begin errors++; $display("FAIL reset_mid_residue: %0d outputs after release want 0", obs1.size() - base); end
   endtask

   task automatic test_random(input bit sel);
      int bo, be, d;
      int o[$], e[$];
      bit c[$];
      bit done, prev_stall, ov, ordy;
      int prev_d;
      pulse_clr(sel);
      bo = sel ? obs4.size() : obs1.size();
      be = sel ? exp4.size() : exp1.size();
      done = 1'b0;
      prev_stall = 1'b0;
      prev_d = 0;
      fork
         begin
            for (int k = 0; k < 120; k++) begin
               drive(sel, int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16);
               if ($urandom_range(0, 3) == 0) begin idle(sel); wait_cycles(int'($urandom_range(1, 2))); end
            end
            idle(sel);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               ov   = sel ? b4.out_valid : b1.out_valid;
               ordy = sel ? b4.out_ready : b1.out_ready;
               d    = sel ? int'(b4.disc_out) : int'(b1.disc_out);
               if (prev_stall) begin
                  checks++;
                  if (!ov || d !== prev_d) begin
                     errors++; $display("FAIL rand%0d_stall: valid=%b disc=%0d want valid=1 disc=%0d", sel, ov, d, prev_d);
                  end
               end
               prev_stall = ov && !ordy;
               prev_d = d;
               @(posedge clk); #1;
               if (sel) b4.out_ready = ($urandom_range(0, 3) != 0);
               else     b1.out_ready = ($urandom_range(0, 3) != 0);
            end
            b1.out_ready = 1'b1;
            b4.out_ready = 1'b1;
         end
      join
      wait_cycles(10);
      if (sel) begin o = obs4[bo:$]; c = oc4[bo:$]; e = exp4[be:$]; end
      else     begin o = obs1[bo:$]; c = oc1[bo:$]; e = exp1[be:$]; end
      checks++;
      if (o.size() !== e.size()) begin
         errors++; $display("FAIL rand%0d_count: got %0d outputs want %0d", sel, o.size(), e.size());
      end else begin
         for (int k = 0; k < o.size(); k++) begin
            checks++;
            if (o[k] !== e[k] || c[k] !== (e[k] > 0)) begin
               errors++; $display("FAIL rand%0d_out%0d: got disc=%0d chip=%b want disc=%0d chip=%b", sel, k, o[k], c[k], e[k], e[k] > 0);
            end
         end
         $display("random decim=%0d: %0d outputs compared", sel ? 4 : 1, o.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      b1.in_valid = 1'b0; b1.i_in = '0; b1.q_in = '0; b1.out_ready = 1'b1;
      b4.in_valid = 1'b0; b4.i_in = '0; b4.q_in = '0; b4.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_extremes();
      test_decim4();
      test_backpressure();
      test_sync_clr();
      test_reset_mid();
      test_random(0);
      test_random(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
